// File: rtl/ucsbece154_icache_pkg.sv
// Shared types, default geometry and address-field widths for the instruction cache.
// Pure declarations: no latency, no flow control.
package ucsbece154_icache_pkg;

    localparam int ICACHE_NUM_SETS    = 8;
    localparam int ICACHE_NUM_WAYS    = 2;
    localparam int ICACHE_BLOCK_WORDS = 4;
    localparam int ICACHE_WO_W        = $clog2(ICACHE_BLOCK_WORDS);
    localparam int ICACHE_IDX_W       = $clog2(ICACHE_NUM_SETS);
    localparam int ICACHE_TAG_W       = 32 - 2 - ICACHE_WO_W - ICACHE_IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } icache_state_t;

    // Clears the word-offset and byte bits, giving the burst base address.
    function automatic logic [31:0] icache_block_base(input logic [31:0] addr, input int wo_w);
        return addr & ~((32'd1 << (wo_w + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/ucsbece154_icache_if.sv
// Fetch-side and imem-side signals of the instruction cache in one bundle.
// master = fetch stage plus imem (environment), slave = the cache itself.
interface ucsbece154_icache_if;

    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic [31:0] Instruction;
    logic        Ready;
    logic        MemReadRequest;
    logic [31:0] MemReadAddress;
    logic [31:0] MemDataIn;
    logic        MemDataReady;

    modport master (
        output ReadEnable, ReadAddress, MemDataIn, MemDataReady,
        input  Instruction, Ready, MemReadRequest, MemReadAddress
    );

    modport slave (
        input  ReadEnable, ReadAddress, MemDataIn, MemDataReady,
        output Instruction, Ready, MemReadRequest, MemReadAddress
    );

endinterface

// File: rtl/ucsbece154_icache_way.sv
// One cache way: valid/tag/data arrays, asynchronous read, synchronous write.
// Reads are combinational; writes land at the clock edge; no flow control.
module ucsbece154_icache_way #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int TAG_W       = 25,
    localparam int IDX_W      = $clog2(NUM_SETS),
    localparam int WO_W       = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] index,
    input  logic [WO_W-1:0]  wo,
    input  logic             wr_word_en,
    input  logic [31:0]      wr_data,
    input  logic             wr_tag_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             inval,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [31:0]         data_q [NUM_SETS][BLOCK_WORDS];

    assign rd_valid = valid_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index][wo];

    always_ff @(posedge clk) begin
        if (reset)
            valid_q <= '0;
        else if (inval)
            valid_q[index] <= 1'b0;
        else if (wr_tag_en)
            valid_q[index] <= 1'b1;
    end

    // Tag and data are plain storage; only valid needs a reset.
    always_ff @(posedge clk) begin
        if (wr_tag_en)
            tag_q[index] <= wr_tag;
        if (wr_word_en)
            data_q[index][wo] <= wr_data;
    end

endmodule

// File: rtl/ucsbece154_icache.sv
// 2-way set-associative read-only I-cache: hit same cycle, miss bursts a block from imem.
// Miss: Ready rises 1 cycle after the final beat; imem gaps hold the beat counter indefinitely.
module ucsbece154_icache
    import ucsbece154_icache_pkg::*;
#(
    parameter int NUM_SETS    = ICACHE_NUM_SETS,
    parameter int NUM_WAYS    = ICACHE_NUM_WAYS,
    parameter int BLOCK_WORDS = ICACHE_BLOCK_WORDS
) (
    input  logic               clk,
    input  logic               reset,
    ucsbece154_icache_if.slave bus
);

    localparam int WO_W  = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - 2 - WO_W - IDX_W;

    icache_state_t       state;
    logic [TAG_W-1:0]    miss_tag;
    logic [IDX_W-1:0]    miss_idx;
    logic                miss_way;
    logic [WO_W-1:0]     beat_cnt;
    logic [NUM_SETS-1:0] lru;
    logic                mem_req;
    logic [31:0]         mem_addr;

    logic [WO_W-1:0]     addr_wo;
    logic [IDX_W-1:0]    addr_idx;
    logic [TAG_W-1:0]    addr_tag;
    logic [IDX_W-1:0]    way_idx;
    logic [WO_W-1:0]     way_wo;

    logic [NUM_WAYS-1:0] rd_valid;
    logic [NUM_WAYS-1:0] way_hit;
    logic [NUM_WAYS-1:0] wr_word_en;
    logic [NUM_WAYS-1:0] wr_tag_en;
    logic [NUM_WAYS-1:0] inval;
    logic [TAG_W-1:0]    rd_tag  [NUM_WAYS];
    logic [31:0]         rd_data [NUM_WAYS];

    logic idle;
    logic lookup_hit;
    logic miss_start;
    logic hit_way;
    logic victim;
    logic beat_wr;
    logic final_beat;

    assign addr_wo  = bus.ReadAddress[2 +: WO_W];
    assign addr_idx = bus.ReadAddress[2 + WO_W +: IDX_W];
    assign addr_tag = bus.ReadAddress[31 -: TAG_W];

    // Outside IDLE the arrays are addressed by the latched miss, not by fetch.
    assign idle    = (state == IDLE);
    assign way_idx = idle ? addr_idx : miss_idx;
    assign way_wo  = idle ? addr_wo  : beat_cnt;

    assign lookup_hit = idle & ~reset & bus.ReadEnable & (|way_hit);
    assign miss_start = idle & bus.ReadEnable & ~(|way_hit);
    assign hit_way    = way_hit[1];
    assign victim     = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru[addr_idx]);

    assign beat_wr    = ((state == REQ) || (state == FILL)) & bus.MemDataReady;
    assign final_beat = beat_wr & (beat_cnt == WO_W'(BLOCK_WORDS - 1));

    assign bus.Ready          = lookup_hit;
    assign bus.Instruction    = lookup_hit ? rd_data[hit_way] : 32'h0;
    assign bus.MemReadRequest = mem_req;
    assign bus.MemReadAddress = mem_addr;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign way_hit[w]    = rd_valid[w] & (rd_tag[w] == addr_tag);
        assign wr_word_en[w] = beat_wr & (miss_way == 1'(w));
        assign wr_tag_en[w]  = final_beat & (miss_way == 1'(w));
        // Victim loses valid at miss entry so a half-filled line can never hit.
        assign inval[w]      = miss_start & (victim == 1'(w));

        ucsbece154_icache_way #(
            .NUM_SETS    (NUM_SETS),
            .BLOCK_WORDS (BLOCK_WORDS),
            .TAG_W       (TAG_W)
        ) u_way (
            .clk        (clk),
            .reset      (reset),
            .index      (way_idx),
            .wo         (way_wo),
            .wr_word_en (wr_word_en[w]),
            .wr_data    (bus.MemDataIn),
            .wr_tag_en  (wr_tag_en[w]),
            .wr_tag     (miss_tag),
            .inval      (inval[w]),
            .rd_valid   (rd_valid[w]),
            .rd_tag     (rd_tag[w]),
            .rd_data    (rd_data[w])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            lru      <= '0;
            beat_cnt <= '0;
            miss_tag <= '0;
            miss_idx <= '0;
            miss_way <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lookup_hit) begin
                        lru[addr_idx] <= ~hit_way;
                    end else if (miss_start) begin
                        miss_tag <= addr_tag;
                        miss_idx <= addr_idx;
                        miss_way <= victim;
                        beat_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= icache_block_base(bus.ReadAddress, WO_W);
                        state    <= REQ;
                    end
                end
                REQ, FILL: begin
                    if (final_beat) begin
                        lru[miss_idx] <= ~miss_way;
                        mem_req       <= 1'b0;
                        state         <= IDLE;
                    end else if (beat_wr) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        state    <= FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154_icache.sv
// Self-checking bench: behavioural imem responder plus a recency-list cache model.
module tb_ucsbece154_icache;
    import ucsbece154_icache_pkg::*;

    localparam int NS    = ICACHE_NUM_SETS;
    localparam int BW    = ICACHE_BLOCK_WORDS;
    localparam int WO_W  = ICACHE_WO_W;
    localparam int T0_DELAY = 40;
    localparam logic [31:0] TEXT_BASE = 32'h0001_0000;
    localparam logic [31:0] SET_STRIDE = 32'(NS * BW * 4);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ucsbece154_icache_if bus();

    ucsbece154_icache #(
        .NUM_SETS    (NS),
        .NUM_WAYS    (2),
        .BLOCK_WORDS (BW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // imem knobs
    int t0_delay = T0_DELAY;
    int gap_beat = 0;
    int gap_len  = 0;
    bit spurious = 1'b0;
    int beats_sent = 0;
    int last_beat_cyc = -1;
    logic [31:0] text_seed;

    // fetch results
    int f_cycles, f_req_delay, f_ready_cyc;
    logic [31:0] f_instr, f_req_addr;

    // model: per set, up to two resident blocks, index 0 most recently used
    int unsigned mblk [NS][2];
    int          mcnt [NS];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ text_seed ^ {a[15:0], a[31:16]};
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) mcnt[s] = 0;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        int unsigned b;
        int s;
        b = a >> (2 + WO_W);
        s = int'(b % NS);
        if (mcnt[s] > 0 && mblk[s][0] == b) return 1'b1;
        if (mcnt[s] > 1 && mblk[s][1] == b) begin
            mblk[s][1] = mblk[s][0];
            mblk[s][0] = b;
            return 1'b1;
        end
        mblk[s][1] = mblk[s][0];
        mblk[s][0] = b;
        if (mcnt[s] < 2) mcnt[s]++;
        return 1'b0;
    endfunction

    function automatic int miss_latency();
        return 1 + t0_delay + BW + ((gap_beat > 0 && gap_beat < BW) ? gap_len : 0);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // imem: waits t0_delay cycles after a request appears, then streams the block.
    initial begin : imem
        bit act;
        int wait_n, gap_n;
        logic [31:0] base;
        act = 1'b0; wait_n = 0; gap_n = 0; base = '0;
        bus.MemDataReady = 1'b0;
        bus.MemDataIn = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.MemDataReady = 1'b0;
            bus.MemDataIn = '0;
            if (reset || !bus.MemReadRequest) begin
                act = 1'b0;
                if (spurious && !reset) begin
                    bus.MemDataReady = 1'b1;
                    bus.MemDataIn = $urandom;
                end
            end else begin
                if (!act) begin
                    act = 1'b1; wait_n = t0_delay; gap_n = 0;
                    base = bus.MemReadAddress; beats_sent = 0;
                end
                if (wait_n > 0) wait_n--;
                else if (beats_sent == gap_beat && gap_n < gap_len) gap_n++;
                else if (beats_sent < BW) begin
                    bus.MemDataReady = 1'b1;
                    bus.MemDataIn = word_at(base + 32'(4 * beats_sent));
                    beats_sent++;
                    last_beat_cyc = cyc;
                end
            end
        end
    end

    // Issue one fetch and hold it until Ready (bounded); records what was seen.
    task automatic fetch(input logic [31:0] addr);
        f_cycles = -1; f_req_delay = -1; f_ready_cyc = -1;
        f_instr = '0; f_req_addr = '0;
        bus.ReadEnable = 1'b1;
        bus.ReadAddress = addr;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (f_req_delay < 0 && bus.MemReadRequest) begin
                f_req_delay = c;
                f_req_addr = bus.MemReadAddress;
            end
            if (bus.Ready) begin
                f_cycles = c; f_instr = bus.Instruction; f_ready_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.ReadEnable = 1'b0;
    endtask

    task automatic test_reset();
        bus.ReadEnable = 1'b1;
        bus.ReadAddress = TEXT_BASE;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.Ready !== 1'b0 || bus.Instruction !== 32'h0)
            $display("FAIL reset_lookup: Ready=%b Instruction=%h, want 0/00000000", bus.Ready, bus.Instruction);
        else passed++;
        checks++;
        if (bus.MemReadRequest !== 1'b0 || bus.MemReadAddress !== 32'h0)
            $display("FAIL reset_mem: MemReadRequest=%b MemReadAddress=%h, want 0/00000000", bus.MemReadRequest, bus.MemReadAddress);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Ready !== 1'b0 || bus.Instruction !== 32'h0)
            $display("FAIL post_reset_lookup: Ready=%b Instruction=%h, want 0/00000000", bus.Ready, bus.Instruction);
        else passed++;
        checks++;
        if (bus.MemReadRequest !== 1'b0)
            $display("FAIL post_reset_req: MemReadRequest=%b, want 0", bus.MemReadRequest);
        else passed++;
        @(posedge clk);
        #1;
        bus.ReadEnable = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_cold_miss();
        logic [31:0] a;
        a = TEXT_BASE + 32'h4;
        t0_delay = T0_DELAY; gap_len = 0; gap_beat = 0;
        void'(model_access(a));
        fetch(a);
        checks++;
        if (f_req_delay !== 1)
            $display("FAIL cold_req_delay: request after %0d cycles, want 1", f_req_delay);
        else passed++;
        checks++;
        if (f_req_addr !== TEXT_BASE)
            $display("FAIL cold_req_addr: got %h, want %h", f_req_addr, TEXT_BASE);
        else passed++;
        checks++;
        if (f_cycles !== miss_latency())
            $display("FAIL cold_latency: Ready after %0d cycles, want %0d", f_cycles, miss_latency());
        else passed++;
        checks++;
        if (f_ready_cyc !== last_beat_cyc + 1)
            $display("FAIL cold_ready_after_beat: Ready in cycle %0d, want %0d", f_ready_cyc, last_beat_cyc + 1);
        else passed++;
        checks++;
        if (f_instr !== word_at(a))
            $display("FAIL cold_instr: got %h, want %h", f_instr, word_at(a));
        else passed++;
    endtask

    task automatic test_same_block_hits();
        logic [31:0] offs [3];
        logic [31:0] a;
        offs[0] = 32'h0; offs[1] = 32'h8; offs[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            a = TEXT_BASE + offs[i];
            void'(model_access(a));
            fetch(a);
            checks++;
            if (f_cycles !== 0 || f_req_delay !== -1)
                $display("FAIL hit_%0d_timing: latency=%0d req_delay=%0d, want 0/-1", i, f_cycles, f_req_delay);
            else passed++;
            checks++;
            if (f_instr !== word_at(a))
                $display("FAIL hit_%0d_instr: got %h, want %h", i, f_instr, word_at(a));
            else passed++;
        end
    endtask

    task automatic test_lru_conflict();
        logic [31:0] seq [5];
        logic [31:0] a;
        bit exp_hit;
        seq[0] = TEXT_BASE + SET_STRIDE;          // B
        seq[1] = TEXT_BASE + 32'h4;               // A
        seq[2] = TEXT_BASE + 2 * SET_STRIDE + 8;  // C evicts B
        seq[3] = TEXT_BASE + 32'hC;               // A
        seq[4] = TEXT_BASE + SET_STRIDE + 4;      // B again
        t0_delay = 3;
        for (int i = 0; i < 5; i++) begin
            a = seq[i];
            exp_hit = model_access(a);
            fetch(a);
            checks++;
            if ((f_cycles == 0) !== exp_hit || f_cycles < 0)
                $display("FAIL lru_%0d_hit: addr=%h latency=%0d, want hit=%0d", i, a, f_cycles, exp_hit);
            else passed++;
            checks++;
            if (f_instr !== word_at(a))
                $display("FAIL lru_%0d_instr: got %h, want %h", i, f_instr, word_at(a));
            else passed++;
        end
    endtask

    task automatic test_burst_gap();
        logic [31:0] d;
        d = TEXT_BASE + 32'h44;
        t0_delay = T0_DELAY; gap_beat = 2; gap_len = 3;
        void'(model_access(d));
        fetch(d);
        checks++;
        if (f_cycles !== miss_latency() || f_ready_cyc !== last_beat_cyc + 1)
            $display("FAIL gap_latency: latency=%0d ready_cyc=%0d, want %0d/%0d", f_cycles, f_ready_cyc, miss_latency(), last_beat_cyc + 1);
        else passed++;
        gap_len = 0;
        for (int w = 0; w < BW; w++) begin
            d = TEXT_BASE + 32'h40 + 32'(4 * w);
            void'(model_access(d));
            fetch(d);
            checks++;
            if (f_cycles !== 0 || f_instr !== word_at(d))
                $display("FAIL gap_word_%0d: latency=%0d instr=%h, want 0/%h", w, f_cycles, f_instr, word_at(d));
            else passed++;
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] e;
        bit found;
        e = TEXT_BASE + 32'hA8;
        t0_delay = 4; gap_len = 0;
        found = 1'b0;
        beats_sent = 0;
        bus.ReadEnable = 1'b1;
        bus.ReadAddress = e;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (beats_sent == 2) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) $display("FAIL midfill_beats: beat 1 never delivered, beats=%0d want 2", beats_sent);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.Ready !== 1'b0)
            $display("FAIL midfill_ready_in_reset: Ready=%b, want 0", bus.Ready);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.ReadEnable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.MemReadRequest !== 1'b0 || bus.Ready !== 1'b0)
            $display("FAIL midfill_abort: MemReadRequest=%b Ready=%b, want 0/0", bus.MemReadRequest, bus.Ready);
        else passed++;
        @(posedge clk);
        #1;
        model_reset();
        void'(model_access(e));
        fetch(e);
        checks++;
        if (f_req_delay !== 1 || f_cycles !== miss_latency())
            $display("FAIL midfill_refetch: req_delay=%0d latency=%0d, want 1/%0d", f_req_delay, f_cycles, miss_latency());
        else passed++;
        checks++;
        if (f_instr !== word_at(e))
            $display("FAIL midfill_instr: got %h, want %h", f_instr, word_at(e));
        else passed++;
        void'(model_access(TEXT_BASE));
        fetch(TEXT_BASE);
        checks++;
        if (f_cycles <= 0)
            $display("FAIL midfill_old_line: latency=%0d, want a miss after reset", f_cycles);
        else passed++;
    endtask

    task automatic test_read_disabled();
        logic [31:0] m;
        bit exp_hit;
        m = TEXT_BASE + 3 * SET_STRIDE + 32'h4;
        t0_delay = 2;
        spurious = 1'b1;
        bus.ReadEnable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.ReadAddress = (c % 2 == 0) ? m : TEXT_BASE;
            @(negedge clk);
            checks++;
            if (bus.Ready !== 1'b0 || bus.Instruction !== 32'h0 || bus.MemReadRequest !== 1'b0)
                $display("FAIL disabled_%0d: Ready=%b Instruction=%h MemReadRequest=%b, want 0/0/0", c, bus.Ready, bus.Instruction, bus.MemReadRequest);
            else passed++;
            @(posedge clk);
            #1;
        end
        spurious = 1'b0;
        exp_hit = model_access(m);
        fetch(m);
        checks++;
        if ((f_cycles == 0) !== exp_hit || f_instr !== word_at(m))
            $display("FAIL disabled_then_read: latency=%0d instr=%h, want hit=%0d instr=%h", f_cycles, f_instr, exp_hit, word_at(m));
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] a, aw;
        bit exp_hit;
        for (int i = 0; i < 80; i++) begin
            t0_delay = $urandom_range(0, 5);
            gap_beat = $urandom_range(1, BW - 1);
            gap_len  = $urandom_range(0, 3);
            a = TEXT_BASE + 32'($urandom_range(0, 3)) * SET_STRIDE
                + 32'($urandom_range(0, 3) * BW * 4)
                + 32'($urandom_range(0, BW - 1) * 4) + 32'($urandom_range(0, 3));
            aw = a & ~32'h3;
            exp_hit = model_access(a);
            fetch(a);
            checks++;
            if ((f_cycles == 0) !== exp_hit || (!exp_hit && f_cycles !== miss_latency()))
                $display("FAIL rand_%0d_timing: addr=%h latency=%0d, want hit=%0d miss_lat=%0d", i, a, f_cycles, exp_hit, miss_latency());
            else passed++;
            checks++;
            if (f_instr !== word_at(aw))
                $display("FAIL rand_%0d_instr: addr=%h got %h, want %h", i, a, f_instr, word_at(aw));
            else passed++;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        text_seed = $urandom;
        bus.ReadEnable = 1'b0;
        bus.ReadAddress = '0;
        model_reset();
        test_reset();
        test_cold_miss();
        test_same_block_hits();
        test_lru_conflict();
        test_burst_gap();
        test_reset_mid_fill();
        test_read_disabled();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
